beep_player: RTL and testbench

//  Consumer of the beat index produced by the beat counter: maps each 9-bit beat index to a note code via an

---
 rtl/beep_player_if.sv | 35 +++
 rtl/beep_player.sv | 192 +++++++++++++++++++
 tb/tb_beep_player.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/beep_player_if.sv
// ============================================================================
// Module      : beep_player_if
// Description : Beat-index input and buzzer/status outputs of beep_player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface beep_player_if;
  logic [8:0] pitch_num;
  logic       mute;
  logic       beep;
  logic [4:0] note_code;
  logic       note_valid;
  logic       song_end;

  modport master (
    output pitch_num,
    output mute,
    input  beep,
    input  note_code,
    input  note_valid,
    input  song_end
  );

  modport slave (
    input  pitch_num,
    input  mute,
    output beep,
    output note_code,
    output note_valid,
    output song_end
  );
endinterface

`default_nettype wire

// File: rtl/beep_player.sv
// ============================================================================
// Module      : beep_player
// Description : Maps beat index to a note through a score ROM and drives a
//               50%-duty square wave at that pitch. Optional NOTE_GAP_EN
//               inserts GAP_CYC silent cycles at every note change.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beep_player #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SONG_LEN = 256,
  parameter int GAP_CYC  = 250_000
) (
  input  wire logic     sys_clk,
  input  wire logic     sys_rst,
  beep_player_if.slave  bus
);

`ifdef NOTE_GAP_EN
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_GAP  = 2'd1,
    S_TONE = 2'd2,
    S_REST = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_TONE = 2'd2,
    S_REST = 2'd3
  } state_t;
`endif

  localparam logic [8:0] c_beat_mask = 9'(SONG_LEN - 1);

  function automatic logic [23:0] f_half(input int freq);
    return 24'(CLK_FREQ / (2 * freq));
  endfunction

  state_t      r_state, w_state_next;
  logic [8:0]  r_pitch_q, w_pitch_next;
  logic [4:0]  r_note_code, w_note_next;
  logic [23:0] r_half_cnt, w_half_cnt_next;
  logic        r_tone, w_tone_next;
  logic        r_beep, w_beep_next;
  logic        r_note_valid, w_valid_next;
  logic        r_song_end, w_song_end_next;
  logic        w_chg;
  logic [8:0]  w_beat_q;
  logic [4:0]  w_rom_code;
  logic [23:0] w_half;
`ifdef NOTE_GAP_EN
  logic [23:0] r_gap_cnt, w_gap_cnt_next;
`endif

  assign w_chg    = (bus.pitch_num != r_pitch_q);
  assign w_beat_q = r_pitch_q & c_beat_mask;

  // Score: beat n plays code n+1 for the first 21 beats, rest afterwards.
  assign w_rom_code = (w_beat_q <= 9'd20) ? 5'(w_beat_q + 9'd1) : 5'd0;

  function automatic logic f_is_tone(input logic [4:0] code);
    return (code != 5'd0) && (code <= 5'd21);
  endfunction

  always_comb begin
    w_half = 24'd0;
    case (r_note_code)
      5'd1:  w_half = f_half(262);
      5'd2:  w_half = f_half(294);
      5'd3:  w_half = f_half(330);
      5'd4:  w_half = f_half(349);
      5'd5:  w_half = f_half(392);
      5'd6:  w_half = f_half(440);
      5'd7:  w_half = f_half(494);
      5'd8:  w_half = f_half(523);
      5'd9:  w_half = f_half(587);
      5'd10: w_half = f_half(659);
      5'd11: w_half = f_half(698);
      5'd12: w_half = f_half(784);
      5'd13: w_half = f_half(880);
      5'd14: w_half = f_half(988);
      5'd15: w_half = f_half(1047);
      5'd16: w_half = f_half(1175);
      5'd17: w_half = f_half(1319);
      5'd18: w_half = f_half(1397);
      5'd19: w_half = f_half(1568);
      5'd20: w_half = f_half(1760);
      5'd21: w_half = f_half(1976);
      default: w_half = 24'd0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_LOAD;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_pitch_next    = r_pitch_q;
    w_note_next     = r_note_code;
    w_half_cnt_next = r_half_cnt;
    w_tone_next     = r_tone;
    w_beep_next     = 1'b0;
    w_song_end_next = 1'b0;
`ifdef NOTE_GAP_EN
    w_gap_cnt_next  = r_gap_cnt;
`endif
    // A new beat index overrides whatever the FSM was doing.
    if (w_chg) begin
      w_pitch_next    = bus.pitch_num;
      w_state_next    = S_LOAD;
      w_song_end_next = ((bus.pitch_num & c_beat_mask) == 9'd0);
    end else begin
      case (r_state)
        S_LOAD: begin
          w_note_next     = w_rom_code;
          w_half_cnt_next = 24'd0;
          w_tone_next     = 1'b0;
`ifdef NOTE_GAP_EN
          w_gap_cnt_next  = 24'd0;
          w_state_next    = S_GAP;
`else
          w_state_next    = f_is_tone(w_rom_code) ? S_TONE : S_REST;
`endif
        end
`ifdef NOTE_GAP_EN
        S_GAP: begin
          if (r_gap_cnt == 24'(GAP_CYC - 1)) begin
            w_gap_cnt_next = 24'd0;
            w_state_next   = f_is_tone(r_note_code) ? S_TONE : S_REST;
          end else begin
            w_gap_cnt_next = r_gap_cnt + 24'd1;
          end
        end
`endif
        S_TONE: begin
          if (r_half_cnt == w_half - 24'd1) begin
            w_half_cnt_next = 24'd0;
            w_tone_next     = ~r_tone;
          end else begin
            w_half_cnt_next = r_half_cnt + 24'd1;
          end
          // Mute gates only the pin so the tone phase is preserved.
          w_beep_next = w_tone_next & ~bus.mute;
        end
        S_REST: begin
          w_half_cnt_next = 24'd0;
          w_tone_next     = 1'b0;
        end
        default: w_state_next = S_LOAD;
      endcase
    end
    w_valid_next = (w_state_next == S_TONE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pitch_q    <= 9'd0;
      r_note_code  <= 5'd0;
      r_half_cnt   <= 24'd0;
      r_tone       <= 1'b0;
      r_beep       <= 1'b0;
      r_note_valid <= 1'b0;
      r_song_end   <= 1'b0;
`ifdef NOTE_GAP_EN
      r_gap_cnt    <= 24'd0;
`endif
    end else begin
      r_pitch_q    <= w_pitch_next;
      r_note_code  <= w_note_next;
      r_half_cnt   <= w_half_cnt_next;
      r_tone       <= w_tone_next;
      r_beep       <= w_beep_next;
      r_note_valid <= w_valid_next;
      r_song_end   <= w_song_end_next;
`ifdef NOTE_GAP_EN
      r_gap_cnt    <= w_gap_cnt_next;
`endif
    end
  end

  assign bus.beep       = r_beep;
  assign bus.note_code  = r_note_code;
  assign bus.note_valid = r_note_valid;
  assign bus.song_end   = r_song_end;

endmodule

`default_nettype wire

// File: tb/tb_beep_player.sv
// ============================================================================
// Module      : tb_beep_player
// Description : Self-checking bench for beep_player with a cycle-level
//               behavioural model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beep_player;
  localparam int CLK_FREQ = 1_000_000;
  localparam int SONG_LEN = 32;
  localparam int GAP_CYC  = 10;
`ifdef NOTE_GAP_EN
  localparam int G = GAP_CYC;
`else
  localparam int G = 0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  beep_player_if bus();

  beep_player #(
    .CLK_FREQ (CLK_FREQ),
    .SONG_LEN (SONG_LEN),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int freq_tab [0:21] = '{0, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659,
                          698, 784, 880, 988, 1047, 1175, 1319, 1397, 1568, 1760, 1976};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_code(input int p);
    int beat;
    beat = p % SONG_LEN;
    return (beat <= 20) ? beat + 1 : 0;
  endfunction

  function automatic int exp_half(input int c);
    return CLK_FREQ / (2 * freq_tab[c]);
  endfunction

  // Model: outputs as a function of edges elapsed since the last accepted beat.
  int m_pitch = 0, m_n = 0, m_code = 0;
  bit m_beep = 0, m_valid = 0, m_song_end = 0;

  always @(posedge sys_clk) begin
    int k, h;
    if (sys_rst) begin
      m_pitch = 0; m_n = 0; m_code = 0;
      m_beep = 0; m_valid = 0; m_song_end = 0;
    end else begin
      if (int'(bus.pitch_num) != m_pitch) begin
        m_pitch    = int'(bus.pitch_num);
        m_n        = 0;
        m_beep     = 0;
        m_valid    = 0;
        m_song_end = ((m_pitch % SONG_LEN) == 0);
      end else begin
        if (m_n < 1_000_000) m_n++;
        m_song_end = 0;
        m_code     = exp_code(m_pitch);
        if (m_code >= 1 && m_code <= 21 && m_n >= 1 + G) begin
          k       = m_n - 1 - G;
          h       = exp_half(m_code);
          m_valid = 1;
          m_beep  = (((k / h) % 2) == 1) && !bus.mute;
        end else begin
          m_valid = 0;
          m_beep  = 0;
        end
      end
      #1;
      if (!sys_rst) begin
        chk("model_beep", int'(bus.beep), int'(m_beep));
        chk("model_note_code", int'(bus.note_code), m_code);
        chk("model_note_valid", int'(bus.note_valid), int'(m_valid));
        chk("model_song_end", int'(bus.song_end), int'(m_song_end));
      end
    end
  end

  int se_cnt = 0;
  always @(negedge sys_clk) if (!sys_rst && bus.song_end) se_cnt++;

  // Waits for a full high phase and the following low phase of beep.
  task automatic measure(input string name, output int hi, output int lo);
    int t;
    hi = 0; lo = 0;
    t = 0;
    while (bus.beep && t < 20000) begin @(negedge sys_clk); t++; end
    while (!bus.beep && t < 20000) begin @(negedge sys_clk); t++; end
    while (bus.beep && t < 20000) begin @(negedge sys_clk); t++; hi++; end
    while (!bus.beep && t < 20000) begin @(negedge sys_clk); t++; lo++; end
    if (t >= 20000) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic cycles_to_valid(output int c);
    c = 0;
    do begin @(negedge sys_clk); c++; end while (!bus.note_valid && c < 1000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int hi, lo, s0, c, h1;
    bus.pitch_num = 9'd0;
    bus.mute      = 1'b0;
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_beep", int'(bus.beep), 0);
    chk("rst_note_code", int'(bus.note_code), 0);
    chk("rst_note_valid", int'(bus.note_valid), 0);
    chk("rst_song_end", int'(bus.song_end), 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("boot_note_code", int'(bus.note_code), 1);
    chk("boot_no_song_end", se_cnt, 0);

    // A4 sustained
    bus.pitch_num = 9'd5;
    repeat (3) @(negedge sys_clk);
    chk("a4_code", int'(bus.note_code), 6);
    measure("a4", hi, lo);
    chk("a4_high", hi, 1136);
    chk("a4_low", lo, 1136);

    // rest beat
    bus.pitch_num = 9'd25;
    h1 = 0;
    repeat (5000) begin @(negedge sys_clk); if (bus.beep || bus.note_valid) h1++; end
    chk("rest_code", int'(bus.note_code), 0);
    chk("rest_silent", h1, 0);

    // song wrap 31 -> 32
    bus.pitch_num = 9'd31;
    repeat (3) @(negedge sys_clk);
    s0 = se_cnt;
    bus.pitch_num = 9'd32;
    repeat (5) @(negedge sys_clk);
    chk("wrap32_song_end", se_cnt - s0, 1);
    chk("wrap32_code", int'(bus.note_code), 1);
    measure("c4", hi, lo);
    chk("c4_high", hi, 1908);

    // B6 with mute
    bus.pitch_num = 9'd20;
    repeat (3) @(negedge sys_clk);
    chk("b6_code", int'(bus.note_code), 21);
    measure("b6", hi, lo);
    chk("b6_high", hi, 253);
    bus.mute = 1'b1;
    h1 = 0;
    repeat (1000) begin @(negedge sys_clk); if (bus.beep) h1++; end
    chk("mute_silent", h1, 0);
    chk("mute_valid", int'(bus.note_valid), 1);
    bus.mute = 1'b0;
    measure("b6_unmute", hi, lo);
    chk("b6_unmute_high", hi, 253);
    chk("b6_unmute_low", lo, 253);

    // index wrap 511 -> 0
    bus.pitch_num = 9'd511;
    repeat (3) @(negedge sys_clk);
    s0 = se_cnt;
    bus.pitch_num = 9'd0;
    repeat (3) @(negedge sys_clk);
    chk("wrap511_song_end", se_cnt - s0, 1);
    chk("wrap511_code", int'(bus.note_code), 1);

    // note change latency (includes articulation gap when enabled)
    bus.pitch_num = 9'd3;
    repeat (30) @(negedge sys_clk);
    bus.pitch_num = 9'd4;
    cycles_to_valid(c);
    chk("chg_latency", c, 2 + G);
    chk("chg_code", int'(bus.note_code), 5);
    bus.pitch_num = 9'd6;
    repeat (30) @(negedge sys_clk);
    bus.pitch_num = 9'd7;
    repeat (4) @(negedge sys_clk);
    bus.pitch_num = 9'd8;
    cycles_to_valid(c);
    chk("restart_latency", c, 2 + G);
    chk("restart_code", int'(bus.note_code), 9);

    // asynchronous reset mid-tone
    bus.pitch_num = 9'd20;
    repeat (300) @(negedge sys_clk);
    chk("pre_rst_code", int'(bus.note_code), 21);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_beep", int'(bus.beep), 0);
    chk("arst_note_code", int'(bus.note_code), 0);
    chk("arst_note_valid", int'(bus.note_valid), 0);
    chk("arst_song_end", int'(bus.song_end), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (600) @(negedge sys_clk);
    chk("post_rst_code", int'(bus.note_code), 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
